trace_uart_fifo: RTL and testbench
==================================

// Module: trace_uart_fifo
//
// PURPOSE
//   Buffers characters the CPU writes to TRACE_REG (IO offset 0x000) and drains them into the uart
//   transmitter with a strobe/busy handshake. Sits between system-control IO decode and uart_inst.
//   Software can burst-write trace text without polling uart_busy for every byte.
//   Exposes fill level, an idle flag and a sticky overflow flag for the IO status read-back word.
//
// PARAMETERS
//   DEPTH   16                  entries; power of two, >= 2
//   AW      $clog2(DEPTH)       pointer width (derived, not overridden)
//
// PORTS
//   clk_sys           in   1     system clock, 25 MHz
//   reset_n           in   1     synchronous, active-low reset
//   wr_valid_i        in   1     1-cycle write strobe from IO decode (TRACE_REG write)
//   wr_data_i         in   8     character to enqueue
//   clr_overflow_i    in   1     1-cycle strobe; clears overflow_o
//   uart_busy_i       in   1     uart transmitter busy
//   uart_wr_strobe_o  out  1     1-cycle send strobe to uart
//   uart_data_o       out  8     byte presented to uart; held stable between strobes
//   level_o           out  AW+1  current entry count, 0..DEPTH
//   full_o            out  1     level_o == DEPTH
//   empty_o           out  1     level_o == 0
//   idle_o            out  1     empty, drain FSM in S_IDLE and !uart_busy_i (flush complete)
//   overflow_o        out  1     sticky: a write was dropped because the FIFO was full
//
// BEHAVIOUR
//   Reset (reset_n=0 at clk edge): rd/wr pointers=0, level_o=0, empty_o=1, full_o=0,
//     overflow_o=0, uart_wr_strobe_o=0, uart_data_o=8'h00, FSM=S_IDLE. Applies mid-transfer too:
//     queued bytes are discarded; a byte already strobed to the uart is left to finish there.
//   Push: wr_valid_i && !full_o -> store at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//     wr_valid_i && full_o -> byte dropped, overflow_o<=1. A pop in the same cycle frees no space
//     for that write; full_o is evaluated on the pre-edge level.
//   Pop: only in S_IDLE (see FSM). level_o <= level_o + push - pop; a simultaneous push and pop
//     leaves level unchanged. Pointers are AW bits and wrap naturally; full/empty come from level.
//   overflow_o: a set and clr_overflow_i in the same cycle -> set wins (stays 1).
//   Drain FSM (enum drain_state_t):
//     S_IDLE:   if !empty_o && !uart_busy_i: uart_data_o <= mem[rd_ptr], uart_wr_strobe_o <= 1,
//               rd_ptr++, level decremented, -> S_SETTLE. Otherwise stay.
//     S_SETTLE: strobe <= 0; unconditional 1 cycle to cover the uart busy-assert latency; -> S_WAIT.
//     S_WAIT:   when !uart_busy_i -> S_IDLE.
//   Latency: a write into an empty FIFO with the uart idle -> uart_wr_strobe_o high 2 cycles after
//     wr_valid_i (1 cycle to write, 1 cycle to pop/strobe). Minimum 3 cycles between strobes.
//   uart_wr_strobe_o is registered and is high for exactly one cycle per popped byte.
//   Byte order out equals byte order in; no byte is ever emitted twice.
//
// STRUCTURE
//   Shared package sys_pkg: IO offset constants (TRACE_REG=12'h000, BG_COLOR=12'h004,
//     SYS_STATUS=12'h008) and typedef enum logic[1:0] drain_state_t {S_IDLE,S_SETTLE,S_WAIT}.
//   One sub-module: sync_fifo #(WIDTH=8, DEPTH) (storage, pointers, level, full/empty; push/pop
//     ports; registered rdata-free combinational head output). The drain FSM and the overflow
//     flag live in trace_uart_fifo. Storage is inferred distributed RAM; no reset on the array.
//   Top-level integration: SYS_STATUS read = {26'b0, level_o[4:0]? no: {24'b0, level_o, overflow_o,
//     full_o, idle_o}} is assembled in system control, not here.
//
// TESTING
//   1. Reset, write 'A' (8'h41), uart_busy_i held 0 -> strobe exactly 2 cycles later with
//      uart_data_o=8'h41; level_o returns to 0; idle_o=1 once busy is released.
//   2. Back-to-back writes "Hello" with a uart model that holds busy for 10 cycles after each
//      strobe -> 5 strobes in order 48 65 6C 6C 6F, >= 11 cycles apart; no duplicates or losses.
//   3. uart held busy, 17 writes 0x00..0x10 -> level_o=16, full_o=1, overflow_o=1, byte 0x10
//      never emitted. Release busy -> 0x00..0x0F drain in order.
//   4. Full FIFO with a push and pop in the same cycle -> push dropped, level 16->15, overflow set.
//      clr_overflow_i coinciding with a further drop -> overflow_o stays 1.
//   5. reset_n low for 1 cycle with 8 bytes queued and the FSM in S_WAIT -> next cycle level_o=0,
//      FSM=S_IDLE, no further strobes. New write 0x5A -> sent normally.
//   6. Pointer wrap: 40 single bytes pushed and drained one at a time -> all 40 emitted in order.

Source files
------------

// File: rtl/trace_uart_fifo_pkg.sv
// Shared system-control definitions: IO register offsets and the trace drain FSM encoding.
package trace_uart_fifo_pkg;

  localparam logic [11:0] TRACE_REG  = 12'h000;
  localparam logic [11:0] BG_COLOR   = 12'h004;
  localparam logic [11:0] SYS_STATUS = 12'h008;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WAIT   = 2'd2
  } drain_state_t;

endpackage

// File: rtl/trace_uart_fifo_if.sv
// Trace FIFO bus: IO-decode write side, uart handshake side and status outputs.
interface trace_uart_fifo_if
  import trace_uart_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic              wr_valid_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              clr_overflow_i;
  logic              uart_busy_i;
  logic              uart_wr_strobe_o;
  logic [DATA_W-1:0] uart_data_o;
  logic [LW-1:0]     level_o;
  logic              full_o;
  logic              empty_o;
  logic              idle_o;
  logic              overflow_o;

  modport master (
    output wr_valid_i, wr_data_i, clr_overflow_i, uart_busy_i,
    input  uart_wr_strobe_o, uart_data_o, level_o, full_o, empty_o, idle_o, overflow_o
  );

  modport slave (
    input  wr_valid_i, wr_data_i, clr_overflow_i, uart_busy_i,
    output uart_wr_strobe_o, uart_data_o, level_o, full_o, empty_o, idle_o, overflow_o
  );

endinterface

// File: rtl/trace_uart_fifo_sync_fifo.sv
// Synchronous FIFO: unreset storage array, wrapping pointers, level-derived full/empty,
// combinational head-of-queue output.
module trace_uart_fifo_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_data_c_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // Full is judged on the pre-edge level, so a same-cycle pop never makes room for a push.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
    else if (!push_ok && pop_ok) level_d = level_q - LW'(1);
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_c_o = mem_q[rd_ptr_q];
  assign level_o       = level_q;
  assign full_o        = full_q;
  assign empty_o       = empty_q;

endmodule

// File: rtl/trace_uart_fifo.sv
// Trace character buffer between IO decode and the uart: queues TRACE_REG writes and
// drains them one at a time with a strobe/busy handshake.
module trace_uart_fifo
  import trace_uart_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  trace_uart_fifo_if.slave bus
);

  drain_state_t      state_q, state_d;
  logic              strobe_q, strobe_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] head_c;
  logic              fifo_full, fifo_empty;
  logic              pop_c;

  trace_uart_fifo_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .push_i        (bus.wr_valid_i),
    .push_data_i   (bus.wr_data_i),
    .pop_i         (pop_c),
    .head_data_c_o (head_c),
    .level_o       (bus.level_o),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty)
  );

  // Drain FSM: SETTLE covers the cycle before the uart raises busy after a strobe.
  always_comb begin
    state_d  = state_q;
    strobe_d = 1'b0;
    data_d   = data_q;
    pop_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !bus.uart_busy_i) begin
          pop_c    = 1'b1;
          strobe_d = 1'b1;
          data_d   = head_c;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.uart_busy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky drop flag; a new drop outranks a same-cycle clear.
  always_comb begin
    overflow_d = overflow_q;
    if (bus.wr_valid_i && fifo_full) overflow_d = 1'b1;
    else if (bus.clr_overflow_i)     overflow_d = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      strobe_q   <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      strobe_q   <= strobe_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.uart_wr_strobe_o = strobe_q;
  assign bus.uart_data_o      = data_q;
  assign bus.full_o           = fifo_full;
  assign bus.empty_o          = fifo_empty;
  assign bus.overflow_o       = overflow_q;
  assign bus.idle_o           = fifo_empty && (state_q == S_IDLE) && !bus.uart_busy_i;

endmodule

// File: tb/tb_trace_uart_fifo.sv
// Directed bench for trace_uart_fifo with a behavioural uart that holds busy after each strobe.
module tb_trace_uart_fifo;
  import trace_uart_fifo_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  trace_uart_fifo_if #(.DEPTH(DEPTH)) bus ();

  trace_uart_fifo #(.DEPTH(DEPTH)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #20 clk_sys = ~clk_sys;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // uart model: records every strobed byte, then stays busy for hold_cycles cycles
  logic       force_busy  = 1'b0;
  int         hold_cycles = 0;
  int         busy_cnt    = 0;
  logic [7:0] rx_q [$];
  int         rx_cyc [$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (bus.uart_wr_strobe_o === 1'b1) begin
      rx_q.push_back(bus.uart_data_o);
      rx_cyc.push_back(cyc);
      busy_cnt = hold_cycles;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
  end

  assign bus.uart_busy_i = force_busy || (busy_cnt > 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_rx(input int target, input int budget);
    int k = 0;
    while (rx_q.size() < target && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = b;
    tick();
    bus.wr_valid_i = 1'b0;
  endtask

  initial begin
    int base;
    logic [7:0] hello [5];
    logic [7:0] exp_b;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    bus.wr_valid_i     = 1'b0;
    bus.wr_data_i      = 8'h00;
    bus.clr_overflow_i = 1'b0;

    // reset state
    reset_n = 1'b0;
    tick(2);
    check("rst_level",    32'(bus.level_o), 32'd0);
    check("rst_empty",    32'(bus.empty_o), 32'd1);
    check("rst_full",     32'(bus.full_o), 32'd0);
    check("rst_overflow", 32'(bus.overflow_o), 32'd0);
    check("rst_strobe",   32'(bus.uart_wr_strobe_o), 32'd0);
    check("rst_data",     32'(bus.uart_data_o), 32'h00);
    reset_n = 1'b1;
    tick();

    // 1: single byte, uart idle -> strobe two cycles after the write strobe
    hold_cycles = 0;
    base = rx_q.size();
    write_byte(8'h41);
    check("t1_strobe_c1", 32'(bus.uart_wr_strobe_o), 32'd0);
    check("t1_level_c1",  32'(bus.level_o), 32'd1);
    tick();
    check("t1_strobe_c2", 32'(bus.uart_wr_strobe_o), 32'd1);
    check("t1_data",      32'(bus.uart_data_o), 32'h41);
    check("t1_level_c2",  32'(bus.level_o), 32'd0);
    check("t1_idle_busy", 32'(bus.idle_o), 32'd0);
    tick();
    check("t1_strobe_c3", 32'(bus.uart_wr_strobe_o), 32'd0);
    check("t1_data_hold", 32'(bus.uart_data_o), 32'h41);
    tick(3);
    check("t1_idle",      32'(bus.idle_o), 32'd1);
    check("t1_rx_count",  32'(rx_q.size() - base), 32'd1);

    // 2: "Hello" back-to-back, uart busy 10 cycles per byte
    hold_cycles = 10;
    base = rx_q.size();
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = hello[i];
      tick();
    end
    bus.wr_valid_i = 1'b0;
    wait_rx(base + 5, 200);
    tick(30);
    check("t2_rx_count", 32'(rx_q.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("t2_byte", 32'(rx_q[base + i]), 32'(hello[i]));
      if (i > 0) check("t2_gap_ge11", 32'((rx_cyc[base + i] - rx_cyc[base + i - 1]) >= 11), 32'd1);
    end

    // 3: uart stuck busy, 17 writes -> 16 stored, last dropped
    force_busy  = 1'b1;
    hold_cycles = 2;
    base = rx_q.size();
    for (int i = 0; i < 17; i++) begin
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = 8'(i);
      tick();
    end
    bus.wr_valid_i = 1'b0;
    check("t3_level",    32'(bus.level_o), 32'd16);
    check("t3_full",     32'(bus.full_o), 32'd1);
    check("t3_overflow", 32'(bus.overflow_o), 32'd1);
    check("t3_no_tx",    32'(rx_q.size() - base), 32'd0);

    // 4: clear coinciding with another drop keeps the flag; a lone clear drops it
    bus.clr_overflow_i = 1'b1;
    write_byte(8'h77);
    bus.clr_overflow_i = 1'b0;
    check("t4_set_wins",  32'(bus.overflow_o), 32'd1);
    check("t4_level_16",  32'(bus.level_o), 32'd16);
    bus.clr_overflow_i = 1'b1;
    tick();
    bus.clr_overflow_i = 1'b0;
    check("t4_cleared",   32'(bus.overflow_o), 32'd0);
    // release busy with a push in the same cycle as the pop: push still dropped
    force_busy = 1'b0;
    write_byte(8'hEE);
    check("t4_level_15",  32'(bus.level_o), 32'd15);
    check("t4_full_drop", 32'(bus.full_o), 32'd0);
    check("t4_ovf_reset", 32'(bus.overflow_o), 32'd1);
    check("t4_strobe",    32'(bus.uart_wr_strobe_o), 32'd1);
    check("t4_first",     32'(bus.uart_data_o), 32'h00);
    wait_rx(base + 16, 400);
    tick(20);
    check("t3_drain_cnt", 32'(rx_q.size() - base), 32'd16);
    for (int i = 0; i < 16; i++) check("t3_drain_byte", 32'(rx_q[base + i]), 32'(i));
    check("t3_empty_end", 32'(bus.empty_o), 32'd1);
    bus.clr_overflow_i = 1'b1;
    tick();
    bus.clr_overflow_i = 1'b0;

    // 5: reset with 8 queued and FSM waiting on the uart
    hold_cycles = 50;
    base = rx_q.size();
    for (int i = 0; i < 9; i++) begin
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = 8'(8'h80 + i);
      tick();
    end
    bus.wr_valid_i = 1'b0;
    check("t5_level_8",  32'(bus.level_o), 32'd8);
    check("t5_in_wait",  32'(dut.state_q), 32'(S_WAIT));
    check("t5_one_tx",   32'(rx_q.size() - base), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t5_rst_level", 32'(bus.level_o), 32'd0);
    check("t5_rst_empty", 32'(bus.empty_o), 32'd1);
    check("t5_rst_state", 32'(dut.state_q), 32'(S_IDLE));
    check("t5_rst_data",  32'(bus.uart_data_o), 32'h00);
    tick(60);
    check("t5_no_more",   32'(rx_q.size() - base), 32'd1);
    check("t5_idle",      32'(bus.idle_o), 32'd1);
    write_byte(8'h5A);
    wait_rx(base + 2, 20);
    check("t5_new_cnt",   32'(rx_q.size() - base), 32'd2);
    check("t5_new_byte",  32'(rx_q[base + 1]), 32'h5A);
    tick(60);

    // 6: 40 single bytes, each drained before the next -> pointers wrap twice
    hold_cycles = 3;
    base = rx_q.size();
    for (int i = 0; i < 40; i++) begin
      write_byte(8'(i * 7 + 1));
      wait_rx(base + i + 1, 30);
      tick(6);
    end
    check("t6_count", 32'(rx_q.size() - base), 32'd40);
    for (int i = 0; i < 40; i++) begin
      exp_b = 8'(i * 7 + 1);
      check("t6_byte", 32'(rx_q[base + i]), 32'(exp_b));
    end
    check("t6_idle",  32'(bus.idle_o), 32'd1);
    check("t6_level", 32'(bus.level_o), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #(40 * 50000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
